snn_spike_dma_writer: RTL and testbench

Downstream drain stage for the SNN accelerator's output spike stream. It accepts 32-bit spike events (timestep in bits [31:16], neuron id in bits [15:0]) over a valid/ready handshake. Each event is written as one Wishbone classic single write on the accelerator's `dma_*` master port into a host-owned ring buffer in system memory. It maintains the write pointer, occupancy, full back-pressure and a level-threshold interrupt for the host driver.

---
 rtl/snn_spike_dma_writer.sv | 190 +++++++++++++++++++
 tb/tb_snn_spike_dma_writer.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_spike_dma_writer.sv
// -----------------------------------------------------------------------------
// snn_spike_dma_writer
//
// Drains the accelerator's output spike stream into a host-owned ring buffer.
// Every accepted 32-bit event ({timestep[31:16], neuron_id[15:0]}) becomes
// one Wishbone classic single write on the dma_* master port. The block keeps
// the ring write pointer, the occupancy seen against the host's rd_ptr, full
// back-pressure (one slot always left empty) and a level-crossing interrupt.
//
// Optional feature macro: SNN_DMA_TIMEOUT_EN
//   defined   -> bus watchdog: a cycle that sees no ack for TIMEOUT_CYCLES
//                cycles is dropped and the sticky err flag is set.
//   undefined -> BUS waits for ack indefinitely, err is constant 0.
//
// Handshake: an event transfers on every rising clk edge where
// spk_valid & spk_ready are both 1. spk_ready is combinational from registered
// state plus enable/flush and never depends on spk_valid.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   enable, flush       acceptance enable, one-cycle clear request
//   base_addr           ring base byte address (bits [1:0] ignored)
//   ring_len            ring size in words (2..2^PTR_WIDTH)
//   rd_ptr              host consumer index
//   irq_thresh          level threshold for irq, 0 disables
//   spk_valid/ready/data  event stream input
//   dma_*               Wishbone classic master (write only)
//   wr_ptr, level, full ring status
//   busy                1 while the FSM is in BUS (exposes FSM state)
//   written_cnt         events committed to memory (wraps at 2^32)
//   irq                 one-cycle pulse when a commit crosses irq_thresh
//   err                 sticky bus timeout flag
// -----------------------------------------------------------------------------
module snn_spike_dma_writer #(
  parameter int PTR_WIDTH      = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 flush,
  input  logic [31:0]          base_addr,
  input  logic [PTR_WIDTH:0]   ring_len,
  input  logic [PTR_WIDTH-1:0] rd_ptr,
  input  logic [PTR_WIDTH:0]   irq_thresh,
  input  logic                 spk_valid,
  input  logic [31:0]          spk_data,
  output logic                 spk_ready,
  output logic [31:0]          dma_adr_o,
  output logic [31:0]          dma_dat_o,
  output logic                 dma_we_o,
  output logic                 dma_stb_o,
  output logic                 dma_cyc_o,
  input  logic                 dma_ack_i,
  output logic [PTR_WIDTH-1:0] wr_ptr,
  output logic [PTR_WIDTH:0]   level,
  output logic                 full,
  output logic                 busy,
  output logic [31:0]          written_cnt,
  output logic                 irq,
  output logic                 err
);

  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

  localparam logic [PTR_WIDTH:0]   L_ONE = 1;
  localparam logic [PTR_WIDTH:0]   L_TWO = 2;
  localparam logic [PTR_WIDTH-1:0] P_ONE = 1;

  state_t               state;
  logic                 flush_pend;   // flush seen during BUS, applied on ack
  logic [PTR_WIDTH:0]   wr_ext;
  logic [PTR_WIDTH:0]   rd_ext;
  logic [PTR_WIDTH:0]   ring_last;
  logic [PTR_WIDTH:0]   level_next;
  logic [PTR_WIDTH-1:0] wr_ptr_inc;
  logic [31:0]          slot_addr;
  logic                 accept;
  logic                 drop;
  logic                 flush_hit;

  assign wr_ext    = {1'b0, wr_ptr};
  assign rd_ext    = {1'b0, rd_ptr};
  assign ring_last = ring_len - L_ONE;

  always_comb begin
    level = '0;
    if (wr_ext >= rd_ext) level = wr_ext - rd_ext;
    else                  level = wr_ext + ring_len - rd_ext;
  end

  // A commit can only follow an accept made while not full, so the
  // post-commit level is simply one more than the current one.
  assign level_next = level + L_ONE;

  assign full      = (ring_len < L_TWO) | (level == ring_last);
  assign busy      = (state == BUS);
  assign spk_ready = (state == IDLE) & enable & ~full & ~flush;
  assign accept    = spk_valid & spk_ready;
  assign flush_hit = flush | flush_pend;

  assign wr_ptr_inc = (wr_ext == ring_last) ? '0 : wr_ptr + P_ONE;

  // The slot offset has zero low bits, so the sum's low bits are exactly
  // base_addr[1:0]; masking them gives the word-aligned address.
  assign slot_addr = (base_addr + 32'({wr_ptr, 2'b00})) & 32'hFFFF_FFFC;

`ifdef SNN_DMA_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = 1;

  logic [TO_W-1:0] to_cnt;

  // Counter sits at 0 in IDLE, so every BUS entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) to_cnt <= '0;
    else                      to_cnt <= to_cnt + TO_ONE;
  end

  assign drop = (state == BUS) & ~dma_ack_i & (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst)                                                      err <= 1'b0;
    else if (drop)                                                err <= 1'b1;
    else if ((state == IDLE && flush) || (state == BUS && dma_ack_i && flush_hit))
                                                                  err <= 1'b0;
  end
`else
  assign drop = 1'b0;
  // No watchdog: err is constant 0 (the test is false for any legal
  // TIMEOUT_CYCLES and keeps the parameter referenced in this build).
  assign err  = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      flush_pend  <= 1'b0;
      dma_adr_o   <= '0;
      dma_dat_o   <= '0;
      dma_we_o    <= 1'b0;
      dma_stb_o   <= 1'b0;
      dma_cyc_o   <= 1'b0;
      wr_ptr      <= '0;
      written_cnt <= '0;
      irq         <= 1'b0;
    end else begin
      irq <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            wr_ptr      <= '0;
            written_cnt <= '0;
          end else if (accept) begin
            dma_adr_o  <= slot_addr;
            dma_dat_o  <= spk_data;
            dma_we_o   <= 1'b1;
            dma_stb_o  <= 1'b1;
            dma_cyc_o  <= 1'b1;
            flush_pend <= 1'b0;
            state      <= BUS;
          end
        end
        BUS: begin
          if (flush) flush_pend <= 1'b1;
          if (dma_ack_i || drop) begin
            dma_we_o   <= 1'b0;
            dma_stb_o  <= 1'b0;
            dma_cyc_o  <= 1'b0;
            flush_pend <= 1'b0;
            state      <= IDLE;
            if (flush_hit) begin
              // The write landed, but the ring restarts from slot 0.
              wr_ptr      <= '0;
              written_cnt <= '0;
            end else if (dma_ack_i) begin
              wr_ptr      <= wr_ptr_inc;
              written_cnt <= written_cnt + 32'd1;
              irq         <= (irq_thresh != '0) && (level < irq_thresh) &&
                             (level_next >= irq_thresh);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_spike_dma_writer.sv
module tb_snn_spike_dma_writer;

  localparam int PW = 4;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   base_addr = 32'h1000;
  logic [PW:0]   ring_len = 8;
  logic [PW-1:0] rd_ptr = '0;
  logic [PW:0]   irq_thresh = '0;
  logic          spk_valid = 1'b0;
  logic [31:0]   spk_data = '0;
  logic          spk_ready;
  logic [31:0]   dma_adr_o, dma_dat_o;
  logic          dma_we_o, dma_stb_o, dma_cyc_o;
  logic          dma_ack_i = 1'b0;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   level;
  logic          full, busy, irq, err;
  logic [31:0]   written_cnt;

  snn_spike_dma_writer #(.PTR_WIDTH(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .base_addr(base_addr), .ring_len(ring_len), .rd_ptr(rd_ptr),
    .irq_thresh(irq_thresh), .spk_valid(spk_valid), .spk_data(spk_data),
    .spk_ready(spk_ready), .dma_adr_o(dma_adr_o), .dma_dat_o(dma_dat_o),
    .dma_we_o(dma_we_o), .dma_stb_o(dma_stb_o), .dma_cyc_o(dma_cyc_o),
    .dma_ack_i(dma_ack_i), .wr_ptr(wr_ptr), .level(level), .full(full),
    .busy(busy), .written_cnt(written_cnt), .irq(irq), .err(err)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];          // {addr, data} of accepted, uncommitted events
  logic [31:0] log_adr[$], log_dat[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // ---------------- Wishbone slave ----------------
  int          slave_wait = 0;
  bit          slave_never = 1'b0;
  int          stb_cnt = 0;
  logic [31:0] hold_adr, hold_dat;

  always @(negedge clk) begin
    if (dma_stb_o === 1'b1) begin
      if (stb_cnt > 0) begin
        check("adr_stable", dma_adr_o, hold_adr);
        check("dat_stable", dma_dat_o, hold_dat);
      end
      check("ctl_we_cyc", {30'd0, dma_we_o, dma_cyc_o}, 32'd3);
      hold_adr  = dma_adr_o;
      hold_dat  = dma_dat_o;
      dma_ack_i = !slave_never && (stb_cnt >= slave_wait);
      stb_cnt++;
    end else begin
      dma_ack_i = 1'b0;
      stb_cnt   = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk); #1;
    if (dma_ack_i === 1'b1) begin
      log_adr.push_back(dma_adr_o);
      log_dat.push_back(dma_dat_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, spk_ready, 0);
    check({tag, "_adr"}, dma_adr_o, 0);
    check({tag, "_dat"}, dma_dat_o, 0);
    check({tag, "_ctl"}, {29'd0, dma_we_o, dma_stb_o, dma_cyc_o}, 0);
    check({tag, "_wr_ptr"}, wr_ptr, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cnt"}, written_cnt, 0);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic write_one(input logic [31:0] data, output logic [31:0] adr, output logic [31:0] dat);
    bit acc;
    int n0;
    adr = 'x;
    dat = 'x;
    acc = 1'b0;
    spk_data  = data;
    spk_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk); #1;
      if (spk_ready === 1'b1) acc = 1'b1;
      @(posedge clk); #1;
    end
    spk_valid = 1'b0;
    if (!acc) begin
      fail_now("accept_timeout");
      return;
    end
    n0 = log_adr.size();
    for (int i = 0; i < 100 && log_adr.size() == n0; i++) step();
    if (log_adr.size() == n0) begin
      fail_now("commit_timeout");
      return;
    end
    adr = log_adr[$];
    dat = log_dat[$];
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    logic [PW-1:0] rd;
    logic [31:0]   data;
    int            wt;
    logic [31:0]   adr;
    logic [PW-1:0] wr;
    logic [PW:0]   lvl;
    logic          full;
  } vec_t;

  typedef struct {
    logic cyc;
    logic [PW-1:0] wr;
    logic irq;
    logic rdy;
    logic full;
  } cyc_t;

  vec_t vt[9];
  cyc_t ct[8];

  // ---------------- main test ----------------
  initial begin
    logic [31:0] a, d;
    int cyc_seen, irq_seen, n0;
    // ring_len 8, base 0x1000, writes one by one
    vt[0] = '{rd: 0, data: 32'h0001_0005, wt: 0, adr: 32'h1000, wr: 1, lvl: 1, full: 0};
    vt[1] = '{rd: 0, data: 32'h0001_0006, wt: 0, adr: 32'h1004, wr: 2, lvl: 2, full: 0};
    vt[2] = '{rd: 0, data: 32'h0001_0007, wt: 2, adr: 32'h1008, wr: 3, lvl: 3, full: 0};
    vt[3] = '{rd: 0, data: 32'h0002_0001, wt: 0, adr: 32'h100C, wr: 4, lvl: 4, full: 0};
    vt[4] = '{rd: 0, data: 32'h0002_0002, wt: 1, adr: 32'h1010, wr: 5, lvl: 5, full: 0};
    vt[5] = '{rd: 0, data: 32'h0002_0003, wt: 0, adr: 32'h1014, wr: 6, lvl: 6, full: 0};
    vt[6] = '{rd: 0, data: 32'h0003_0009, wt: 0, adr: 32'h1018, wr: 7, lvl: 7, full: 1};
    vt[7] = '{rd: 4, data: 32'h0003_000A, wt: 3, adr: 32'h101C, wr: 0, lvl: 4, full: 0};
    vt[8] = '{rd: 4, data: 32'h0003_000B, wt: 0, adr: 32'h1000, wr: 1, lvl: 5, full: 0};
    // ring_len 4, irq_thresh 2, continuous valid with a zero-wait slave
    ct[0] = '{cyc: 1, wr: 0, irq: 0, rdy: 0, full: 0};
    ct[1] = '{cyc: 0, wr: 1, irq: 0, rdy: 1, full: 0};
    ct[2] = '{cyc: 1, wr: 1, irq: 0, rdy: 0, full: 0};
    ct[3] = '{cyc: 0, wr: 2, irq: 1, rdy: 1, full: 0};
    ct[4] = '{cyc: 1, wr: 2, irq: 0, rdy: 0, full: 0};
    ct[5] = '{cyc: 0, wr: 3, irq: 0, rdy: 0, full: 1};
    ct[6] = '{cyc: 0, wr: 3, irq: 0, rdy: 0, full: 1};
    ct[7] = '{cyc: 0, wr: 3, irq: 0, rdy: 0, full: 1};

    // reset values
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // table-driven single writes
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rd_ptr     = vt[i].rd;
      slave_wait = vt[i].wt;
      write_one(vt[i].data, a, d);
      check($sformatf("vec%0d_adr", i), a, vt[i].adr);
      check($sformatf("vec%0d_dat", i), d, vt[i].data);
      check($sformatf("vec%0d_wr_ptr", i), wr_ptr, vt[i].wr);
      check($sformatf("vec%0d_level", i), level, vt[i].lvl);
      check($sformatf("vec%0d_full", i), full, vt[i].full);
      check($sformatf("vec%0d_cnt", i), written_cnt, i + 1);
    end

    // flush in IDLE
    enable = 1'b0;
    ring_len = 4;
    irq_thresh = 2;
    base_addr = 32'h2000;
    rd_ptr = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle_wr", wr_ptr, 0);
    check("flush_idle_cnt", written_cnt, 0);

    // continuous stream into a 4-slot ring: timing, full, irq
    log_adr.delete();
    log_dat.delete();
    slave_wait = 0;
    spk_data = 32'hABCD_0000;
    spk_valid = 1'b1;
    enable = 1'b1;
    irq_seen = 0;
    for (int s = 0; s < 8; s++) begin
      step();
      irq_seen += int'(irq);
      check($sformatf("cont%0d_cyc", s), dma_cyc_o, ct[s].cyc);
      check($sformatf("cont%0d_wr", s), wr_ptr, ct[s].wr);
      check($sformatf("cont%0d_irq", s), irq, ct[s].irq);
      check($sformatf("cont%0d_ready", s), spk_ready, ct[s].rdy);
      check($sformatf("cont%0d_full", s), full, ct[s].full);
    end
    check("cont_irq_count", irq_seen, 1);
    check("cont_writes", log_adr.size(), 3);
    if (log_adr.size() == 3) begin
      check("cont_adr0", log_adr[0], 32'h2000);
      check("cont_adr1", log_adr[1], 32'h2004);
      check("cont_adr2", log_adr[2], 32'h2008);
    end
    enable = 1'b0;
    irq_thresh = 0;
    rd_ptr = 2;
    step();
    check("drain_level", level, 1);
    check("drain_full", full, 0);
    enable = 1'b1;
    irq_seen = 0;
    for (int s = 0; s < 8; s++) begin
      step();
      irq_seen += int'(irq);
    end
    check("wrap_irq_count", irq_seen, 0);
    check("wrap_writes", log_adr.size(), 5);
    if (log_adr.size() == 5) begin
      check("wrap_adr3", log_adr[3], 32'h200C);
      check("wrap_adr4", log_adr[4], 32'h2000);
    end
    check("wrap_wr", wr_ptr, 1);
    check("wrap_full", full, 1);
    check("wrap_ready", spk_ready, 0);

    // wait states with data/enable toggled mid-cycle
    spk_valid = 1'b0;
    enable = 1'b0;
    rd_ptr = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    ring_len = 8;
    base_addr = 32'h1000;
    slave_wait = 5;
    log_adr.delete();
    log_dat.delete();
    spk_data = 32'hCAFE_0001;
    spk_valid = 1'b1;
    enable = 1'b1;
    step();
    enable = 1'b0;
    cyc_seen = int'(dma_cyc_o);
    for (int s = 0; s < 20; s++) begin
      spk_data = $urandom;
      step();
      cyc_seen += int'(dma_cyc_o);
    end
    check("ws_cyc_cycles", cyc_seen, 6);
    check("ws_commits", log_adr.size(), 1);
    if (log_adr.size() == 1) begin
      check("ws_adr", log_adr[0], 32'h1000);
      check("ws_dat", log_dat[0], 32'hCAFE_0001);
    end
    check("ws_cnt", written_cnt, 1);
    check("ws_wr", wr_ptr, 1);

    // flush during BUS
    spk_valid = 1'b0;
    slave_wait = 3;
    log_adr.delete();
    log_dat.delete();
    spk_data = 32'h5555_AAAA;
    spk_valid = 1'b1;
    enable = 1'b1;
    step();
    spk_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fbus_still_cyc", dma_cyc_o, 1);
    for (int s = 0; s < 20 && dma_cyc_o === 1'b1; s++) step();
    check("fbus_cyc_done", dma_cyc_o, 0);
    check("fbus_wr", wr_ptr, 0);
    check("fbus_cnt", written_cnt, 0);
    check("fbus_commits", log_adr.size(), 1);
    if (log_adr.size() == 1) check("fbus_adr", log_adr[0], 32'h1004);

    // reset during BUS
    slave_wait = 5;
    log_adr.delete();
    log_dat.delete();
    spk_valid = 1'b1;
    enable = 1'b1;
    step();
    check("rbus_cyc_before", dma_cyc_o, 1);
    spk_valid = 1'b0;
    enable = 1'b0;
    rst = 1'b1;
    step();
    check_all_zero("rbus");
    rst = 1'b0;
    check("rbus_commits", log_adr.size(), 0);

    // degenerate ring sizes
    ring_len = 1;
    step();
    enable = 1'b1;
    spk_valid = 1'b1;
    step();
    check("len1_full", full, 1);
    check("len1_ready", spk_ready, 0);
    step();
    check("len1_cyc", dma_cyc_o, 0);
    enable = 1'b0;
    ring_len = 0;
    step();
    enable = 1'b1;
    step();
    check("len0_full", full, 1);
    check("len0_ready", spk_ready, 0);
    spk_valid = 1'b0;
    enable = 1'b0;
    ring_len = 8;
    step();

`ifdef SNN_DMA_TIMEOUT_EN
    // bus watchdog
    slave_wait = 0;
    enable = 1'b1;
    write_one(32'h0000_0077, a, d);
    slave_never = 1'b1;
    spk_valid = 1'b1;
    step();
    spk_valid = 1'b0;
    enable = 1'b0;
    cyc_seen = int'(dma_cyc_o);
    irq_seen = 0;
    for (int s = 0; s < 40; s++) begin
      step();
      cyc_seen += int'(dma_cyc_o);
      irq_seen += int'(irq);
    end
    check("to_cyc_cycles", cyc_seen, TO);
    check("to_err", err, 1);
    check("to_wr", wr_ptr, 1);
    check("to_cnt", written_cnt, 1);
    check("to_irq", irq_seen, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("to_flush_err", err, 0);
    slave_never = 1'b0;
`endif

    // randomized traffic against a modular-arithmetic ring model
    for (int ph = 0; ph < 3; ph++) begin
      int len, th, m_wr, m_rd, m_cnt, mlvl;
      bit m_busy, m_irq, exp_rdy, acc, ack;
      logic [31:0] base;
      logic [63:0] e;
      len = $urandom_range(2, 16);
      th  = $urandom_range(0, len);
      base = $urandom;
      spk_valid = 1'b0;
      enable = 1'b0;
      flush = 1'b0;
      rd_ptr = 0;
      ring_len = (PW + 1)'(len);
      base_addr = base;
      irq_thresh = (PW + 1)'(th);
      slave_wait = 0;
      do_reset();
      m_wr = 0; m_rd = 0; m_cnt = 0; m_busy = 0; m_irq = 0;
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
        spk_valid = ($urandom_range(0, 3) != 0);
        spk_data  = $urandom;
        enable    = ($urandom_range(0, 7) != 0);
        if (!m_busy) slave_wait = $urandom_range(0, 3);
        if ($urandom_range(0, 2) == 0) begin
          mlvl = (m_wr - m_rd + len) % len;
          m_rd = (m_rd + $urandom_range(0, mlvl)) % len;
          rd_ptr = PW'(m_rd);
        end
        @(negedge clk); #1;
        mlvl = (m_wr - m_rd + len) % len;
        exp_rdy = !m_busy && enable && (mlvl != len - 1);
        check("rnd_ready", spk_ready, exp_rdy);
        acc = spk_valid && exp_rdy;
        ack = m_busy && (dma_ack_i === 1'b1);
        if (ack) begin
          if (exp_q.size() == 0) fail_now("rnd_unexpected_write");
          else begin
            e = exp_q.pop_front();
            check("rnd_adr", dma_adr_o, e[63:32]);
            check("rnd_dat", dma_dat_o, e[31:0]);
          end
        end
        @(posedge clk); #1;
        m_irq = 1'b0;
        if (acc) begin
          exp_q.push_back({(base & 32'hFFFF_FFFC) + 32'(m_wr * 4), spk_data});
          m_busy = 1'b1;
        end else if (ack) begin
          m_wr   = (m_wr + 1) % len;
          m_cnt++;
          m_busy = 1'b0;
          m_irq  = (th != 0) && (mlvl < th) && (mlvl + 1 >= th);
        end
        mlvl = (m_wr - m_rd + len) % len;
        check("rnd_cyc", dma_cyc_o, m_busy);
        check("rnd_busy", busy, m_busy);
        check("rnd_wr", wr_ptr, m_wr);
        check("rnd_level", level, mlvl);
        check("rnd_full", full, (mlvl == len - 1));
        check("rnd_cnt", written_cnt, m_cnt);
        check("rnd_irq", irq, m_irq);
        check("rnd_err", err, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
